// File: rtl/sc_statemachine_backg.sv
// rtl/sc_statemachine_backg.sv - background-type register sequencer (clear/load strobes, LFSR road pattern)
// Optional macro BACKG_LOOP_EN: chain levels continuously (END -> CLEAR instead of END -> IDLE).
module sc_statemachine_backg #(
    parameter int          DATAWIDTH     = 8,
    parameter int          TICKS_PER_ROW = 4,
    parameter int          NUM_ROWS      = 16,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5,
    parameter logic [7:0]  TYPE_MASK     = 8'h07
) (
    input  logic                 SC_STATEMACHINEBACKG_CLOCK_50,
    input  logic                 SC_STATEMACHINEBACKG_RESET_InLow,
    input  logic                 SC_STATEMACHINEBACKG_start_InLow,
    input  logic                 SC_STATEMACHINEBACKG_pause_InLow,
    input  logic                 SC_STATEMACHINEBACKG_tick_InHigh,
    output logic                 SC_STATEMACHINEBACKG_clear_OutLow,
    output logic                 SC_STATEMACHINEBACKG_load_OutLow,
    output logic [DATAWIDTH-1:0] SC_STATEMACHINEBACKG_data_OutBUS,
    output logic [7:0]           SC_STATEMACHINEBACKG_rowcount_OutBUS,
    output logic                 SC_STATEMACHINEBACKG_busy_OutHigh,
    output logic                 SC_STATEMACHINEBACKG_levelend_OutHigh
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [7:0] SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_ROW - 1);
    localparam logic [7:0] ROWS_LAST = 8'(NUM_ROWS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_END   = 3'd4
    } state_t;

    state_t     state;
    state_t     stateNext;
    logic [7:0] tickCount;
    logic [7:0] rowCount;
    logic [7:0] lfsrReg;
    logic [7:0] typeWord;
    logic       countedTick;

    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    assign countedTick = SC_STATEMACHINEBACKG_tick_InHigh & SC_STATEMACHINEBACKG_pause_InLow;
    assign typeWord    = lfsrReg & TYPE_MASK;

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (!SC_STATEMACHINEBACKG_start_InLow) stateNext = ST_CLEAR;
            ST_CLEAR: stateNext = ST_RUN;
            ST_RUN:   if (countedTick && (tickCount == TICK_LAST)) stateNext = ST_LOAD;
            ST_LOAD:  stateNext = ((rowCount + 8'd1) == ROWS_LAST) ? ST_END : ST_RUN;
`ifdef BACKG_LOOP_EN
            ST_END:   stateNext = ST_CLEAR;
`else
            ST_END:   stateNext = ST_IDLE;
`endif
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they equal a decode of the
    // state register while being glitch-free flop outputs.
    always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or negedge SC_STATEMACHINEBACKG_RESET_InLow) begin
        if (!SC_STATEMACHINEBACKG_RESET_InLow) begin
            state                                 <= ST_IDLE;
            tickCount                             <= 8'd0;
            rowCount                              <= 8'd0;
            lfsrReg                               <= SEED_EFF;
            SC_STATEMACHINEBACKG_clear_OutLow     <= 1'b1;
            SC_STATEMACHINEBACKG_load_OutLow      <= 1'b1;
            SC_STATEMACHINEBACKG_busy_OutHigh     <= 1'b0;
            SC_STATEMACHINEBACKG_levelend_OutHigh <= 1'b0;
        end else begin
            state                                 <= stateNext;
            SC_STATEMACHINEBACKG_clear_OutLow     <= (stateNext != ST_CLEAR);
            SC_STATEMACHINEBACKG_load_OutLow      <= (stateNext != ST_LOAD);
            SC_STATEMACHINEBACKG_busy_OutHigh     <= (stateNext != ST_IDLE);
            SC_STATEMACHINEBACKG_levelend_OutHigh <= (stateNext == ST_END);
            case (state)
                ST_CLEAR: begin
                    lfsrReg   <= SEED_EFF;
                    rowCount  <= 8'd0;
                    tickCount <= 8'd0;
                end
                ST_RUN: begin
                    if (countedTick) begin
                        tickCount <= (tickCount == TICK_LAST) ? 8'd0 : tickCount + 8'd1;
                    end
                end
                ST_LOAD: begin
                    lfsrReg  <= lfsrStep(lfsrReg);
                    rowCount <= rowCount + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign SC_STATEMACHINEBACKG_data_OutBUS     = typeWord[DATAWIDTH-1:0];
    assign SC_STATEMACHINEBACKG_rowcount_OutBUS = rowCount;

endmodule

// File: tb/tb_sc_statemachine_backg.sv
// tb/tb_sc_statemachine_backg.sv - randomized self-checking bench for sc_statemachine_backg
module tb_sc_statemachine_backg;

    localparam int TICKS_PER_ROW = 4;
    localparam int NUM_ROWS      = 16;
    localparam int SEED          = 165;
    localparam int MASK          = 7;

    logic       clk = 1'b0;
    logic       rstN;
    logic       startN;
    logic       pauseN;
    logic       tick;
    logic       clearN;
    logic       loadN;
    logic [7:0] dataBus;
    logic [7:0] rowBus;
    logic       busy;
    logic       levelEnd;

    int passCount  = 0;
    int checkCount = 0;

    // Reference: level phase 0=idle 1=clear 2=run 3=load 4=end; LFSR derived from rows loaded.
    int mPhase;
    int mRows;
    int mTicks;
    int loadsSeen = 0;
    int levelsSeen = 0;

    sc_statemachine_backg dut (
        .SC_STATEMACHINEBACKG_CLOCK_50        (clk),
        .SC_STATEMACHINEBACKG_RESET_InLow     (rstN),
        .SC_STATEMACHINEBACKG_start_InLow     (startN),
        .SC_STATEMACHINEBACKG_pause_InLow     (pauseN),
        .SC_STATEMACHINEBACKG_tick_InHigh     (tick),
        .SC_STATEMACHINEBACKG_clear_OutLow    (clearN),
        .SC_STATEMACHINEBACKG_load_OutLow     (loadN),
        .SC_STATEMACHINEBACKG_data_OutBUS     (dataBus),
        .SC_STATEMACHINEBACKG_rowcount_OutBUS (rowBus),
        .SC_STATEMACHINEBACKG_busy_OutHigh    (busy),
        .SC_STATEMACHINEBACKG_levelend_OutHigh(levelEnd)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        checkCount++;
        if (got == exp) passCount++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    endtask

    function automatic int lfsrAt(input int n);
        int v = SEED;
        for (int i = 0; i < n; i++) v = (v / 2) ^ ((v % 2 == 1) ? 184 : 0);
        return v;
    endfunction

    task automatic modelReset();
        mPhase = 0;
        mRows  = 0;
        mTicks = 0;
    endtask

    task automatic modelStep(input bit s, input bit p, input bit t);
        case (mPhase)
            0: if (!s) mPhase = 1;
            1: begin mPhase = 2; mRows = 0; mTicks = 0; end
            2: if (t && p) begin
                   mTicks++;
                   if (mTicks == TICKS_PER_ROW) begin mTicks = 0; mPhase = 3; end
               end
            3: begin mRows++; mPhase = (mRows == NUM_ROWS) ? 4 : 2; end
`ifdef BACKG_LOOP_EN
            4: mPhase = 1;
`else
            4: mPhase = 0;
`endif
            default: mPhase = 0;
        endcase
    endtask

    task automatic checkOutputs();
        checkVal("clear", int'(clearN), (mPhase == 1) ? 0 : 1);
        checkVal("load", int'(loadN), (mPhase == 3) ? 0 : 1);
        checkVal("busy", int'(busy), (mPhase == 0) ? 0 : 1);
        checkVal("levelend", int'(levelEnd), (mPhase == 4) ? 1 : 0);
        checkVal("rowcount", int'(rowBus), mRows);
        checkVal("data", int'(dataBus), lfsrAt(mRows) & MASK);
        if (mPhase == 3) loadsSeen++;
        if (mPhase == 4) levelsSeen++;
    endtask

    task automatic cycle(input bit s, input bit p, input bit t);
        @(negedge clk);
        checkOutputs();
        startN = s;
        pauseN = p;
        tick   = t;
        modelStep(s, p, t);
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++)
            cycle(($urandom % 16) != 0, ($urandom % 6) != 0, ($urandom % 2) == 1);
    endtask

    initial begin
        bit found;
        rstN   = 1'b0;
        startN = 1'b1;
        pauseN = 1'b1;
        tick   = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rstN = 1'b1;

        // Idle after reset, then one start pulse and a full level of back-to-back ticks.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b1, 1'b1);
        checkVal("loads_first_level", loadsSeen, NUM_ROWS);
        checkVal("levelend_first_level", levelsSeen, 1);

        // Paused ticks, start pulses while busy, then random traffic.
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1);
        randomCycles(3000);

        // Assert reset while a LOAD strobe is active.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            checkOutputs();
            if (!loadN) found = 1'b1;
            else begin
                startN = 1'b0; pauseN = 1'b1; tick = 1'b1;
                modelStep(1'b0, 1'b1, 1'b1);
            end
        end
        checkVal("load_reached", int'(found), 1);
        rstN = 1'b0;
        #1;
        modelReset();
        checkVal("rst_load", int'(loadN), 1);
        checkVal("rst_clear", int'(clearN), 1);
        checkVal("rst_busy", int'(busy), 0);
        checkVal("rst_rowcount", int'(rowBus), 0);
        checkVal("rst_data", int'(dataBus), 5);
        startN = 1'b1;
        tick   = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        randomCycles(1500);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
